// File: rtl/gremlin_scheduler_pkg.sv
// Shared types and constants for the gremlin lifecycle scheduler.
// Play-field edges, slot states, direction codes, spawn-position mapping.
package gremlin_scheduler_pkg;

    localparam logic [10:0] EDGE_LEFT  = 11'd5;
    localparam logic [10:0] EDGE_RIGHT = 11'd779;
    localparam logic [10:0] EDGE_UP    = 11'd105;
    localparam logic [10:0] EDGE_DOWN  = 11'd563;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_ALIVE = 3'd2,
        ST_TOMB  = 3'd3,
        ST_WAIT  = 3'd4
    } slot_state_e;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd0,
        DIR_UR    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_DR    = 3'd3,
        DIR_DOWN  = 3'd4,
        DIR_DL    = 3'd5,
        DIR_LEFT  = 3'd6,
        DIR_UL    = 3'd7
    } dir_e;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [2:0]  dir;
    } spawn_pos_t;

    // Fold raw LFSR bits into the inclusive play-field rectangle.
    function automatic spawn_pos_t map_spawn(input logic [15:0] r);
        spawn_pos_t  p;
        logic [10:0] rx;
        logic [10:0] ry;
        rx = {1'b0, r[9:0]};
        ry = {2'b00, r[15:7]};
        if (rx > (EDGE_RIGHT - EDGE_LEFT))
            p.x = rx - 11'd507;
        else
            p.x = rx + EDGE_LEFT;
        if (ry > (EDGE_DOWN - EDGE_UP))
            p.y = ry - 11'd151;
        else
            p.y = ry + EDGE_UP;
        p.dir = r[2:0];
        return p;
    endfunction

endpackage

// File: rtl/gremlin_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), steps every clock.
// Seed must be non-zero so the register never locks up.
module gremlin_lfsr
    import gremlin_scheduler_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr
);

    logic fb;

    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= SEED;
        else
            lfsr <= {lfsr[14:0], fb};
    end

endmodule

// File: rtl/gremlin_scheduler.sv
// Gremlin slot lifecycle, round-robin spawn bus and run-over score.
// Define GREM_SCORE_EN to build the score counter; otherwise score is 0.
module gremlin_scheduler
    import gremlin_scheduler_pkg::*;
#(
    parameter int          NUM_GREM       = 4,
    parameter int          RESPAWN_FRAMES = 120,
    parameter int          TOMB_FRAMES    = 180,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vsync_in,
    input  logic                game_en,
    input  logic [NUM_GREM-1:0] hit,
    output logic [NUM_GREM-1:0] spawn,
    output logic [10:0]         spawn_x,
    output logic [10:0]         spawn_y,
    output logic [2:0]          spawn_dir,
    output logic [NUM_GREM-1:0] alive,
    output logic [NUM_GREM-1:0] tomb,
    output logic [7:0]          score
);

    localparam int         PW       = (NUM_GREM > 1) ? $clog2(NUM_GREM) : 1;
    localparam logic [7:0] RESP_CNT = 8'(RESPAWN_FRAMES);
    localparam logic [7:0] TOMB_CNT = 8'(TOMB_FRAMES);

    logic                vs_q;
    logic                tick;
    logic [15:0]         lfsr;
    logic [PW-1:0]       ptr;
    logic [NUM_GREM-1:0] req;
    logic [NUM_GREM-1:0] grant;
    logic [PW-1:0]       grant_idx;
    logic                grant_vld;
    spawn_pos_t          pos;

    always_ff @(posedge clk) begin
        if (reset)
            vs_q <= 1'b0;
        else
            vs_q <= vsync_in;
    end

    assign tick = vsync_in & ~vs_q;

    gremlin_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .lfsr  (lfsr)
    );

    assign pos = map_spawn(lfsr);

    // First requester at or after the pointer wins.
    always_comb begin
        int            idx;
        logic [PW-1:0] sel;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int i = 0; i < NUM_GREM; i++) begin
            idx = (int'(ptr) + i) % NUM_GREM;
            sel = PW'(idx);
            if (!grant_vld && req[sel]) begin
                grant_vld  = 1'b1;
                grant_idx  = sel;
                grant[sel] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spawn     <= '0;
            spawn_x   <= '0;
            spawn_y   <= '0;
            spawn_dir <= '0;
            ptr       <= '0;
        end else begin
            spawn <= grant;
            if (grant_vld) begin
                spawn_x   <= pos.x;
                spawn_y   <= pos.y;
                spawn_dir <= pos.dir;
                if (grant_idx == PW'(NUM_GREM - 1))
                    ptr <= '0;
                else
                    ptr <= grant_idx + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_GREM; k++) begin : g_slot
        slot_state_e st;
        slot_state_e st_nxt;
        logic [7:0]  cnt;
        logic [7:0]  cnt_nxt;

        always_ff @(posedge clk) begin
            if (reset) begin
                st  <= ST_IDLE;
                cnt <= '0;
            end else begin
                st  <= st_nxt;
                cnt <= cnt_nxt;
            end
        end

        always_comb begin
            st_nxt  = st;
            cnt_nxt = cnt;
            if (!game_en) begin
                st_nxt  = ST_IDLE;
                cnt_nxt = '0;
            end else begin
                unique case (st)
                    ST_IDLE: st_nxt = ST_SPAWN;
                    // the slot leaves SPAWN once its pulse is on the bus
                    ST_SPAWN: begin
                        if (spawn[k])
                            st_nxt = ST_ALIVE;
                    end
                    ST_ALIVE: begin
                        if (hit[k]) begin
                            st_nxt  = ST_TOMB;
                            cnt_nxt = TOMB_CNT;
                        end
                    end
                    ST_TOMB: begin
                        if (tick) begin
                            if (cnt == 8'd1) begin
                                st_nxt  = ST_WAIT;
                                cnt_nxt = RESP_CNT;
                            end else begin
                                cnt_nxt = cnt - 8'd1;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (tick) begin
                            if (cnt == 8'd1)
                                st_nxt = ST_SPAWN;
                            else
                                cnt_nxt = cnt - 8'd1;
                        end
                    end
                    default: st_nxt = ST_IDLE;
                endcase
            end
        end

        assign req[k]   = game_en && (st == ST_SPAWN) && !spawn[k];
        assign alive[k] = (st == ST_ALIVE);
        assign tomb[k]  = (st == ST_TOMB);
    end

`ifdef GREM_SCORE_EN
    logic [10:0] hit_sum;
    logic [10:0] score_sum;

    always_comb begin
        hit_sum = '0;
        for (int i = 0; i < NUM_GREM; i++)
            hit_sum = hit_sum + {10'd0, hit[i] & alive[i]};
        score_sum = {3'd0, score} + hit_sum;
    end

    always_ff @(posedge clk) begin
        if (reset)
            score <= '0;
        else if (game_en)
            score <= (score_sum > 11'd255) ? 8'hFF : score_sum[7:0];
    end
`else
    assign score = 8'd0;
`endif

endmodule

// File: tb/tb_gremlin_scheduler.sv
// Self-checking bench for gremlin_scheduler against a slot-lifecycle model.
// Directed scenarios first, then a randomized soak.
module tb_gremlin_scheduler;

    localparam int N    = 4;
    localparam int RESP = 120;
    localparam int TOMB = 180;
`ifdef GREM_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         vsync_in;
    logic         game_en;
    logic [N-1:0] hit;
    logic [N-1:0] spawn;
    logic [10:0]  spawn_x;
    logic [10:0]  spawn_y;
    logic [2:0]   spawn_dir;
    logic [N-1:0] alive;
    logic [N-1:0] tomb;
    logic [7:0]   score;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gremlin_scheduler #(
        .NUM_GREM       (N),
        .RESPAWN_FRAMES (RESP),
        .TOMB_FRAMES    (TOMB),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vsync_in  (vsync_in),
        .game_en   (game_en),
        .hit       (hit),
        .spawn     (spawn),
        .spawn_x   (spawn_x),
        .spawn_y   (spawn_y),
        .spawn_dir (spawn_dir),
        .alive     (alive),
        .tomb      (tomb),
        .score     (score)
    );

    // model phases: 0 idle, 1 wants bus, 2 pulsing, 3 alive, 4 tomb, 5 wait
    int           ph[N];
    int           left_ticks[N];
    int           ptr;
    int           m_score;
    logic [15:0]  m_lfsr;
    logic         m_vs;
    bit           m_tick;
    logic [N-1:0] e_spawn;
    int           e_x;
    int           e_y;
    int           e_dir;
    int           vs_mode;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int          g;
        int          hits;
        int          rx;
        int          ry;
        logic [15:0] cur;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                ph[i]         = 0;
                left_ticks[i] = 0;
            end
            ptr     = 0;
            m_score = 0;
            m_lfsr  = 16'hACE1;
            m_vs    = 1'b0;
            m_tick  = 1'b0;
            e_spawn = '0;
            e_x     = 0;
            e_y     = 0;
            e_dir   = 0;
            return;
        end
        m_tick  = vsync_in && !m_vs;
        m_vs    = vsync_in;
        cur     = m_lfsr;
        m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        e_spawn = '0;
        if (!game_en) begin
            for (int i = 0; i < N; i++) ph[i] = 0;
            return;
        end
        hits = 0;
        for (int i = 0; i < N; i++)
            if (ph[i] == 3 && hit[i]) hits++;
        m_score = (m_score + hits > 255) ? 255 : m_score + hits;
        g = -1;
        for (int j = 0; j < N; j++) begin
            int s;
            s = (ptr + j) % N;
            if (g < 0 && ph[s] == 1) g = s;
        end
        for (int i = 0; i < N; i++) begin
            case (ph[i])
                0: ph[i] = 1;
                1: if (i == g) begin ph[i] = 2; e_spawn[i] = 1'b1; end
                2: ph[i] = 3;
                3: if (hit[i]) begin ph[i] = 4; left_ticks[i] = TOMB; end
                4: if (m_tick) begin
                    left_ticks[i]--;
                    if (left_ticks[i] == 0) begin ph[i] = 5; left_ticks[i] = RESP; end
                end
                5: if (m_tick) begin
                    left_ticks[i]--;
                    if (left_ticks[i] == 0) ph[i] = 1;
                end
                default: ph[i] = 0;
            endcase
        end
        if (g >= 0) begin
            ptr   = (g + 1) % N;
            rx    = int'(cur[9:0]);
            ry    = int'(cur[15:7]);
            e_x   = (rx > 774) ? rx - 507 : rx + 5;
            e_y   = (ry > 458) ? ry - 151 : ry + 105;
            e_dir = int'(cur[2:0]);
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] ea;
        logic [N-1:0] et;
        for (int i = 0; i < N; i++) begin
            ea[i] = (ph[i] == 3);
            et[i] = (ph[i] == 4);
        end
        chk("alive", 32'(alive), 32'(ea));
        chk("tomb", 32'(tomb), 32'(et));
        chk("spawn", 32'(spawn), 32'(e_spawn));
        chk("score", 32'(score), SCORE_EN ? m_score : 0);
        chk("spawn_x", 32'(spawn_x), e_x);
        chk("spawn_y", 32'(spawn_y), e_y);
        chk("spawn_dir", 32'(spawn_dir), e_dir);
        if (spawn != '0) begin
            chk("x_range", 32'(spawn_x >= 5 && spawn_x <= 779), 1);
            chk("y_range", 32'(spawn_y >= 105 && spawn_y <= 563), 1);
        end
    endtask

    task automatic step();
        if (vs_mode == 1)
            vsync_in = ~vsync_in;
        else if (vs_mode == 2)
            vsync_in = 1'($urandom_range(0, 1));
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic wait_alive(input logic [N-1:0] m);
        int n;
        n = 0;
        while ((alive & m) != m && n < 1000) begin
            step();
            n++;
        end
        chk("wait_alive", 32'(alive & m), 32'(m));
    endtask

    initial begin
        int p0;
        int tk;
        int n;
        int s0;
        int rounds;
        reset    = 1'b1;
        game_en  = 1'b0;
        hit      = '0;
        vsync_in = 1'b0;
        vs_mode  = 0;
        step();
        step();
        chk("rst_spawn", 32'(spawn), 0);
        chk("rst_alive", 32'(alive), 0);
        chk("rst_score", 32'(score), 0);

        // 1: four consecutive spawn pulses
        reset   = 1'b0;
        game_en = 1'b1;
        step();
        for (int k = 0; k < N; k++) begin
            step();
            chk("t1_spawn", 32'(spawn), 32'(1 << k));
        end
        step();
        chk("t1_alive", 32'(alive), 32'hF);

        // 2: held hit counts once, then tomb/wait timing
        s0  = m_score;
        hit = 4'b0100;
        for (int i = 0; i < 10; i++) step();
        hit = '0;
        chk("t2_tomb", 32'(tomb), 32'h4);
        chk("t2_score", 32'(score), SCORE_EN ? s0 + 1 : 0);
        vs_mode = 1;
        tk = 0;
        n  = 0;
        while (spawn[2] !== 1'b1 && n < 1000) begin
            step();
            n++;
            if (m_tick) begin
                tk++;
                if (tk == TOMB - 1) chk("t2_tomb_hold", 32'(tomb[2]), 1);
                if (tk == TOMB) chk("t2_tomb_exit", 32'(tomb[2]), 0);
            end
        end
        chk("t2_respawn", 32'(spawn[2]), 1);
        chk("t2_ticks", tk, TOMB + RESP);
        vs_mode = 0;
        step();

        // 3: simultaneous hits
        s0  = m_score;
        hit = 4'b1011;
        step();
        hit = '0;
        chk("t3_tomb", 32'(tomb), 32'hB);
        chk("t3_alive", 32'(alive), 32'h4);
        chk("t3_score", 32'(score), SCORE_EN ? s0 + 3 : 0);

        // 4: saturation
        vs_mode = 1;
        rounds  = 0;
        while (m_score < 252 && rounds < 70) begin
            wait_alive(4'hF);
            hit = 4'hF;
            step();
            hit = '0;
            rounds++;
        end
        wait_alive(4'hF);
        if (m_score == 252) begin
            hit = 4'b0011;
            step();
            chk("t4_254", 32'(score), SCORE_EN ? 254 : 0);
        end
        hit = 4'b1100;
        step();
        hit = '0;
        chk("t4_255", 32'(score), SCORE_EN ? 255 : 0);
        wait_alive(4'hF);
        hit = 4'hF;
        step();
        hit = '0;
        chk("t4_hold", 32'(score), SCORE_EN ? 255 : 0);

        // 5: disable mid-tomb, pending-spawn drop, round-robin restart
        for (int i = 0; i < 20; i++) step();
        s0      = m_score;
        game_en = 1'b0;
        step();
        chk("t5_alive", 32'(alive), 0);
        chk("t5_tomb", 32'(tomb), 0);
        chk("t5_score", 32'(score), SCORE_EN ? s0 : 0);
        game_en = 1'b1;
        step();
        step();
        step();
        game_en = 1'b0;
        step();
        chk("t5_drop", 32'(spawn), 0);
        game_en = 1'b1;
        step();
        p0 = ptr;
        for (int k = 0; k < N; k++) begin
            step();
            chk("t5_rr", 32'(spawn), 32'(1 << ((p0 + k) % N)));
        end
        step();
        chk("t5_alive_all", 32'(alive), 32'hF);

        // 6: reset beats a pending grant and a vsync edge
        vs_mode  = 0;
        vsync_in = 1'b0;
        game_en  = 1'b0;
        step();
        game_en = 1'b1;
        step();
        reset    = 1'b1;
        vsync_in = 1'b1;
        step();
        chk("t6_spawn", 32'(spawn), 0);
        chk("t6_alive", 32'(alive), 0);
        chk("t6_tomb", 32'(tomb), 0);
        chk("t6_xyd", {spawn_x, spawn_y, 7'd0, spawn_dir}, 0);
        reset = 1'b0;
        step();
        step();
        chk("t6_first", 32'(spawn), 1);

        // randomized soak
        vs_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            hit     = N'($urandom);
            game_en = ($urandom_range(0, 99) != 0);
            reset   = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
